// File: rtl/vic_bank_mapper.sv
// VIC-20 cartridge bank mapper.
// Maps the BLK1/2/3/5 8 KiB windows onto ROM banks or RAM slots. The CPU
// programs the mapping through registers in IO3 (0x9C00-0x9FFF), and a soft
// CPU reset sequencer switches the windows from the boot bank to the mapping.
module vic_bank_mapper #(
  parameter int NUM_WIN = 4,
  parameter int BANK_W  = 8,
  parameter int ADDR_W  = 23,
  parameter int RST_LEN = 16,
  parameter logic [BANK_W-1:0] BOOT_BANK = {BANK_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              active,
  input  logic [15:0]       vic_addr,
  input  logic              vic_wr_n,
  input  logic              vic_io3_sel,
  input  logic [3:0]        vic_blk_sel,
  input  logic [7:0]        from_vic,
  output logic [7:0]        to_vic,
  output logic              to_vic_valid,
  output logic [ADDR_W-1:0] mc_addr,
  output logic              mc_wr_n,
  output logic              mc_rom_sel,
  output logic              mc_ram_sel,
  output logic              mc_soft_reset
);

  localparam int CNT_W = (RST_LEN > 2) ? $clog2(RST_LEN) : 1;

  typedef enum logic {
    IDLE,
    PULSE
  } seqState_t;

  seqState_t        r_state;
  seqState_t        w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             r_mapped;
  logic             w_nextMapped;

  logic [7:0]       r_bankLo [4];
  logic [7:0]       r_ctrl   [4];
  logic             r_lock;
  logic [7:0]       r_toVic;
  logic             r_toVicValid;
  logic             r_trigPrev;
  logic             r_activePrev;

  logic [9:0]       w_regAddr;
  logic             w_winSpace;
  logic [1:0]       w_winIdx;
  logic             w_isCtrl;
  logic             w_winValid;
  logic             w_isLock;
  logic             w_isTrig;
  logic             w_wrCycle;
  logic             w_rdCycle;
  logic             w_trig;
  logic             w_trigReq;
  logic             w_activeChg;
  logic             w_rdHit;
  logic [7:0]       w_rdData;

  logic             w_hit;
  logic [1:0]       w_hitIdx;
  logic [BANK_W-1:0] w_bank;
  logic             w_ramEn;
  logic             w_wrEn;

  // Register file lives at 0x080..0x087 (BANKLO/CTRL pairs), 0x0C0 and 0x0C1.
  assign w_regAddr   = vic_addr[9:0];
  assign w_winSpace  = (w_regAddr[9:3] == 7'b0010000);
  assign w_winIdx    = w_regAddr[2:1];
  assign w_isCtrl    = w_regAddr[0];
  assign w_winValid  = w_winSpace && ({30'b0, w_winIdx} < NUM_WIN);
  assign w_isLock    = (w_regAddr == 10'h0C0);
  assign w_isTrig    = (w_regAddr == 10'h0C1);
  assign w_wrCycle   = vic_io3_sel & ~vic_wr_n;
  assign w_rdCycle   = vic_io3_sel & vic_wr_n;
  assign w_trig      = w_wrCycle & w_isTrig;
  assign w_trigReq   = w_trig & ~r_trigPrev;
  assign w_activeChg = active ^ r_activePrev;
  assign w_rdHit     = w_rdCycle & (w_winValid | w_isLock);

  // Select the register value presented on a readback.
  always_comb begin
    w_rdData = 8'h00;
    if (w_isLock) begin
      w_rdData = {7'b0, r_lock};
    end else if (w_isCtrl) begin
      w_rdData = r_ctrl[w_winIdx];
    end else begin
      w_rdData = r_bankLo[w_winIdx];
    end
  end

  // Bank/control registers; frozen once LOCK is set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_bankLo[i] <= 8'h00;
        r_ctrl[i]   <= 8'h00;
      end
    end else if (w_wrCycle && w_winValid && !r_lock) begin
      if (w_isCtrl) begin
        r_ctrl[w_winIdx] <= from_vic;
      end else begin
        r_bankLo[w_winIdx] <= from_vic;
      end
    end
  end

  // LOCK is sticky: it can only be set, and only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lock <= 1'b0;
    end else if (w_wrCycle && w_isLock && from_vic[0]) begin
      r_lock <= 1'b1;
    end
  end

  // Readback data is registered; to_vic holds its last value between reads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_toVic      <= 8'h00;
      r_toVicValid <= 1'b0;
    end else begin
      r_toVicValid <= w_rdHit;
      if (w_rdHit) begin
        r_toVic <= w_rdData;
      end
    end
  end

  // Edge history; reset also loads the current inputs, so no pulse fires on reset exit.
  always_ff @(posedge clk) begin
    r_trigPrev   <= w_trig;
    r_activePrev <= active;
  end

  // Soft-reset sequencer state, counter and mapped flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mapped <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_cnt    <= w_nextCnt;
      r_mapped <= w_nextMapped;
    end
  end

  // Start a pulse on a trigger or an active change; the mapping flips when the pulse ends.
  always_comb begin
    w_nextState  = r_state;
    w_nextCnt    = r_cnt;
    w_nextMapped = r_mapped;
    case (r_state)
      IDLE: begin
        if (w_trigReq || w_activeChg) begin
          w_nextState = PULSE;
          w_nextCnt   = CNT_W'(RST_LEN - 1);
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_nextState  = IDLE;
          w_nextMapped = ~r_mapped;
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Pick the lowest-numbered selected window that exists.
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = 2'd0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (vic_blk_sel[i]) begin
        w_hit    = 1'b1;
        w_hitIdx = 2'(i);
      end
    end
    w_hit = w_hit & active;
  end

  // Until the mapping is enabled every window shows the boot bank, read-only ROM.
  always_comb begin
    w_bank  = BOOT_BANK;
    w_ramEn = 1'b0;
    w_wrEn  = 1'b0;
    if (r_mapped) begin
      w_bank  = BANK_W'({r_ctrl[w_hitIdx][3:0], r_bankLo[w_hitIdx]});
      w_ramEn = r_ctrl[w_hitIdx][7];
      w_wrEn  = r_ctrl[w_hitIdx][6];
    end
  end

  // Memory-side address/selects, purely combinational so no access latency is added.
  always_comb begin
    mc_addr    = ADDR_W'(vic_addr);
    mc_rom_sel = 1'b0;
    mc_ram_sel = 1'b0;
    mc_wr_n    = vic_wr_n;
    if (w_hit) begin
      if (w_ramEn) begin
        mc_ram_sel = 1'b1;
        mc_addr    = {1'b1, {(ADDR_W-16){1'b0}}, w_hitIdx, vic_addr[12:0]};
        mc_wr_n    = vic_wr_n | ~w_wrEn;
      end else begin
        mc_rom_sel = 1'b1;
        mc_addr    = ADDR_W'({w_bank, vic_addr[12:0]});
        mc_wr_n    = 1'b1;
      end
    end
  end

  assign to_vic        = r_toVic;
  assign to_vic_valid  = r_toVicValid;
  assign mc_soft_reset = (r_state == PULSE);

endmodule

// File: tb/tb_vic_bank_mapper.sv
// Testbench for vic_bank_mapper: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the mapper.
module tb_vic_bank_mapper;

  localparam int NUM_WIN = 4;
  localparam int BANK_W  = 8;
  localparam int ADDR_W  = 23;
  localparam int RST_LEN = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              active;
  logic [15:0]       vic_addr;
  logic              vic_wr_n;
  logic              vic_io3_sel;
  logic [3:0]        vic_blk_sel;
  logic [7:0]        from_vic;
  logic [7:0]        to_vic;
  logic              to_vic_valid;
  logic [ADDR_W-1:0] mc_addr;
  logic              mc_wr_n;
  logic              mc_rom_sel;
  logic              mc_ram_sel;
  logic              mc_soft_reset;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model state
  int mBankLo [4];
  int mCtrl   [4];
  bit mLock;
  bit mMapped;
  int mPulseLeft;
  bit mPrevActive;
  bit mPrevTrig;
  bit mToVicValid;
  int mToVic;

  // Expected combinational outputs for the current inputs
  int eAddr;
  bit eRom;
  bit eRam;
  bit eWrN;

  vic_bank_mapper #(
    .NUM_WIN(NUM_WIN),
    .BANK_W (BANK_W),
    .ADDR_W (ADDR_W),
    .RST_LEN(RST_LEN)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .active       (active),
    .vic_addr     (vic_addr),
    .vic_wr_n     (vic_wr_n),
    .vic_io3_sel  (vic_io3_sel),
    .vic_blk_sel  (vic_blk_sel),
    .from_vic     (from_vic),
    .to_vic       (to_vic),
    .to_vic_valid (to_vic_valid),
    .mc_addr      (mc_addr),
    .mc_wr_n      (mc_wr_n),
    .mc_rom_sel   (mc_rom_sel),
    .mc_ram_sel   (mc_ram_sel),
    .mc_soft_reset(mc_soft_reset)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  function automatic bit trigNow();
    return vic_io3_sel && !vic_wr_n && ((int'(vic_addr) % 1024) == 'h0C1);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    int a;
    int w;
    bit inWin;
    bit t;
    a     = int'(vic_addr) % 1024;
    w     = (a - 'h80) / 2;
    inWin = (a >= 'h80) && (a <= 'h87) && (w < NUM_WIN);
    t     = trigNow();
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        mBankLo[i] = 0;
        mCtrl[i]   = 0;
      end
      mLock       = 0;
      mMapped     = 0;
      mPulseLeft  = 0;
      mToVic      = 0;
      mToVicValid = 0;
    end else begin
      if (vic_io3_sel && vic_wr_n && (inWin || a == 'hC0)) begin
        mToVicValid = 1;
        if (a == 'hC0) mToVic = int'(mLock);
        else if (a % 2 == 1) mToVic = mCtrl[w];
        else mToVic = mBankLo[w];
      end else begin
        mToVicValid = 0;
      end
      if (vic_io3_sel && !vic_wr_n) begin
        if (inWin && !mLock) begin
          if (a % 2 == 1) mCtrl[w] = int'(from_vic);
          else mBankLo[w] = int'(from_vic);
        end
        if (a == 'hC0 && from_vic[0]) mLock = 1;
      end
      if (mPulseLeft > 0) begin
        mPulseLeft--;
        if (mPulseLeft == 0) mMapped = !mMapped;
      end else if ((t && !mPrevTrig) || (active != mPrevActive)) begin
        mPulseLeft = RST_LEN;
      end
    end
    mPrevTrig   = t;
    mPrevActive = active;
  endtask

  // Expected memory-side outputs from the model state and current inputs.
  task automatic modelComb();
    int h;
    int bank;
    bit ramEn;
    bit wrEn;
    h = -1;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (active && vic_blk_sel[i] && h < 0) h = i;
    end
    eAddr = int'(vic_addr);
    eRom  = 0;
    eRam  = 0;
    eWrN  = vic_wr_n;
    if (h >= 0) begin
      ramEn = mMapped && (mCtrl[h] >= 128);
      wrEn  = mMapped && ((mCtrl[h] / 64) % 2 == 1);
      bank  = mMapped ? (((mCtrl[h] % 16) * 256 + mBankLo[h]) % (1 << BANK_W))
                      : ((1 << BANK_W) - 1);
      if (ramEn) begin
        eRam  = 1;
        eAddr = (1 << (ADDR_W - 1)) + h * 8192 + int'(vic_addr) % 8192;
        eWrN  = vic_wr_n || !wrEn;
      end else begin
        eRom  = 1;
        eAddr = bank * 8192 + int'(vic_addr) % 8192;
        eWrN  = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic busIdle();
    vic_io3_sel = 1'b0;
    vic_wr_n    = 1'b1;
    from_vic    = 8'h00;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
    vic_blk_sel = 4'b0000;
    vic_io3_sel = 1'b1;
    vic_wr_n    = 1'b0;
    vic_addr    = addr;
    from_vic    = data;
    tick();
    busIdle();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    active      = 1'b1;
    vic_blk_sel = 4'b0000;
    vic_addr    = 16'h0000;
    busIdle();
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    nChecks++;
    if (mc_soft_reset !== 1'b0) begin nFails++; $display("[TB] FAIL reset_soft: got %b want 0", mc_soft_reset); end
    nChecks++;
    if (to_vic_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b want 0", to_vic_valid); end
    nChecks++;
    if (to_vic !== 8'h00) begin nFails++; $display("[TB] FAIL reset_tovic: got %h want 00", to_vic); end
    vic_blk_sel = 4'b0001;
    vic_addr    = 16'h2345;
    #1;
    nChecks++;
    if (mc_rom_sel !== 1'b1 || mc_ram_sel !== 1'b0) begin
      nFails++; $display("[TB] FAIL boot_sel: got rom=%b ram=%b want rom=1 ram=0", mc_rom_sel, mc_ram_sel);
    end
    nChecks++;
    if (mc_addr !== 23'h1FE345) begin nFails++; $display("[TB] FAIL boot_addr: got %h want 1fe345", mc_addr); end
    nChecks++;
    if (mc_wr_n !== 1'b1) begin nFails++; $display("[TB] FAIL boot_wrn: got %b want 1", mc_wr_n); end
    for (int c = 0; c < 3; c++) tick();
    nChecks++;
    if (mc_soft_reset !== 1'b0) begin nFails++; $display("[TB] FAIL reset_exit_pulse: got %b want 0", mc_soft_reset); end
  endtask

  task automatic test_soft_reset_remap();
    int  highCnt;
    int  rises;
    bit  prevSoft;
    highCnt  = 0;
    rises    = 0;
    prevSoft = 0;
    busWrite(16'h9C86, 8'h12);
    busWrite(16'h9C87, 8'h01);
    vic_io3_sel = 1'b1;
    vic_wr_n    = 1'b0;
    vic_addr    = 16'h9CC1;
    from_vic    = 8'hA5;
    for (int c = 0; c < 40; c++) begin
      if (c == 3) busIdle();
      tick();
      if (mc_soft_reset === 1'b1) highCnt++;
      if (mc_soft_reset === 1'b1 && !prevSoft) rises++;
      prevSoft = (mc_soft_reset === 1'b1);
    end
    nChecks++;
    if (highCnt !== RST_LEN) begin nFails++; $display("[TB] FAIL pulse_len: got %0d want %0d", highCnt, RST_LEN); end
    nChecks++;
    if (rises !== 1) begin nFails++; $display("[TB] FAIL pulse_count: got %0d want 1", rises); end
    vic_blk_sel = 4'b1000;
    vic_addr    = 16'hA010;
    #1;
    nChecks++;
    if (mc_addr !== 23'h024010 || mc_rom_sel !== 1'b1) begin
      nFails++; $display("[TB] FAIL blk5_map: got addr=%h rom=%b want addr=024010 rom=1", mc_addr, mc_rom_sel);
    end
  endtask

  task automatic test_ram_window();
    busWrite(16'h9C83, 8'hC0);
    vic_blk_sel = 4'b0010;
    vic_addr    = 16'h4001;
    vic_wr_n    = 1'b0;
    #1;
    nChecks++;
    if (mc_ram_sel !== 1'b1 || mc_rom_sel !== 1'b0) begin
      nFails++; $display("[TB] FAIL ram_sel: got ram=%b rom=%b want ram=1 rom=0", mc_ram_sel, mc_rom_sel);
    end
    nChecks++;
    if (mc_addr !== 23'h402001) begin nFails++; $display("[TB] FAIL ram_addr: got %h want 402001", mc_addr); end
    nChecks++;
    if (mc_wr_n !== 1'b0) begin nFails++; $display("[TB] FAIL ram_wr_enabled: got %b want 0", mc_wr_n); end
    busWrite(16'h9C83, 8'h80);
    vic_blk_sel = 4'b0010;
    vic_addr    = 16'h4001;
    vic_wr_n    = 1'b0;
    #1;
    nChecks++;
    if (mc_wr_n !== 1'b1 || mc_ram_sel !== 1'b1) begin
      nFails++; $display("[TB] FAIL ram_wr_blocked: got wr_n=%b ram=%b want wr_n=1 ram=1", mc_wr_n, mc_ram_sel);
    end
    vic_blk_sel = 4'b0110;
    vic_addr    = 16'h6001;
    #1;
    nChecks++;
    if (mc_addr !== 23'h402001) begin nFails++; $display("[TB] FAIL priority: got %h want 402001", mc_addr); end
    vic_wr_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 29) == 0) active = ~active;
      vic_blk_sel = 4'($urandom);
      vic_wr_n    = 1'($urandom);
      from_vic    = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        vic_io3_sel = 1'b1;
        k = $urandom_range(0, 39);
        if (k < 24) vic_addr = 16'h9C80 + 16'(k % 8);
        else if (k < 28) vic_addr = 16'h9CC1;
        else if (k == 28) vic_addr = 16'h9CC0;
        else vic_addr = 16'h9C00 + 16'($urandom_range(0, 1023));
      end else begin
        vic_io3_sel = 1'b0;
        vic_addr    = 16'($urandom);
      end
      #1;
      modelComb();
      nChecks++;
      if (mc_addr !== ADDR_W'(eAddr)) begin nFails++; $display("[TB] FAIL rnd_addr @%0d: got %h want %h", n, mc_addr, ADDR_W'(eAddr)); end
      nChecks++;
      if (mc_rom_sel !== eRom || mc_ram_sel !== eRam) begin
        nFails++; $display("[TB] FAIL rnd_sel @%0d: got rom=%b ram=%b want rom=%b ram=%b", n, mc_rom_sel, mc_ram_sel, eRom, eRam);
      end
      nChecks++;
      if (mc_wr_n !== eWrN) begin nFails++; $display("[TB] FAIL rnd_wrn @%0d: got %b want %b", n, mc_wr_n, eWrN); end
      nChecks++;
      if (mc_soft_reset !== (mPulseLeft > 0)) begin
        nFails++; $display("[TB] FAIL rnd_soft @%0d: got %b want %b", n, mc_soft_reset, (mPulseLeft > 0));
      end
      nChecks++;
      if (to_vic_valid !== mToVicValid || to_vic !== 8'(mToVic)) begin
        nFails++; $display("[TB] FAIL rnd_readback @%0d: got v=%b d=%h want v=%b d=%h", n, to_vic_valid, to_vic, mToVicValid, 8'(mToVic));
      end
      tick();
    end
    reset_n = 1'b1;
    busIdle();
    tick();
  endtask

  task automatic test_lock_readback();
    active      = 1'b1;
    vic_blk_sel = 4'b0000;
    busIdle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    busWrite(16'h9C80, 8'h33);
    busWrite(16'h9CC0, 8'h01);
    busWrite(16'h9C80, 8'h55);
    vic_io3_sel = 1'b1;
    vic_wr_n    = 1'b1;
    vic_addr    = 16'h9C80;
    #1;
    nChecks++;
    if (to_vic_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rd_early: got %b want 0", to_vic_valid); end
    tick();
    busIdle();
    #1;
    nChecks++;
    if (to_vic_valid !== 1'b1 || to_vic !== 8'h33) begin
      nFails++; $display("[TB] FAIL lock_readback: got v=%b d=%h want v=1 d=33", to_vic_valid, to_vic);
    end
    tick();
    nChecks++;
    if (to_vic_valid !== 1'b0 || to_vic !== 8'h33) begin
      nFails++; $display("[TB] FAIL rd_hold: got v=%b d=%h want v=0 d=33", to_vic_valid, to_vic);
    end
    vic_io3_sel = 1'b1;
    vic_addr    = 16'h9CC0;
    tick();
    busIdle();
    nChecks++;
    if (to_vic_valid !== 1'b1 || to_vic !== 8'h01) begin
      nFails++; $display("[TB] FAIL lock_read: got v=%b d=%h want v=1 d=01", to_vic_valid, to_vic);
    end
  endtask

  task automatic test_active_toggle();
    int highCnt;
    int rises;
    bit prevSoft;
    highCnt  = 0;
    rises    = 0;
    prevSoft = 0;
    vic_blk_sel = 4'b0001;
    vic_addr    = 16'h2000;
    #1;
    nChecks++;
    if (mc_addr !== 23'h1FE000) begin nFails++; $display("[TB] FAIL unmapped_addr: got %h want 1fe000", mc_addr); end
    active = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 2) begin
        vic_io3_sel = 1'b1;
        vic_wr_n    = 1'b0;
        vic_addr    = 16'h9CC1;
      end
      if (c == 3) begin
        busIdle();
        vic_addr = 16'h2000;
      end
      if (c == 4) active = 1'b1;
      tick();
      if (mc_soft_reset === 1'b1) highCnt++;
      if (mc_soft_reset === 1'b1 && !prevSoft) rises++;
      prevSoft = (mc_soft_reset === 1'b1);
    end
    nChecks++;
    if (highCnt !== RST_LEN || rises !== 1) begin
      nFails++; $display("[TB] FAIL toggle_pulse: got len=%0d rises=%0d want len=%0d rises=1", highCnt, rises, RST_LEN);
    end
    #1;
    nChecks++;
    if (mc_addr !== 23'h066000) begin nFails++; $display("[TB] FAIL mapped_toggle: got %h want 066000", mc_addr); end
    busWrite(16'h9CC1, 8'h00);
    tick();
    tick();
    nChecks++;
    if (mc_soft_reset !== 1'b1) begin nFails++; $display("[TB] FAIL midpulse_start: got %b want 1", mc_soft_reset); end
    reset_n = 1'b0;
    tick();
    reset_n     = 1'b1;
    vic_blk_sel = 4'b0001;
    vic_addr    = 16'h2000;
    #1;
    nChecks++;
    if (mc_soft_reset !== 1'b0) begin nFails++; $display("[TB] FAIL abort_pulse: got %b want 0", mc_soft_reset); end
    nChecks++;
    if (mc_addr !== 23'h1FE000) begin nFails++; $display("[TB] FAIL abort_mapped: got %h want 1fe000", mc_addr); end
    for (int c = 0; c < 20; c++) tick();
    nChecks++;
    if (mc_soft_reset !== 1'b0 || mc_addr !== 23'h1FE000) begin
      nFails++; $display("[TB] FAIL after_abort: got soft=%b addr=%h want soft=0 addr=1fe000", mc_soft_reset, mc_addr);
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_soft_reset_remap();
    test_ram_window();
    test_random();
    test_lock_readback();
    test_active_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
